adc_spi_ctrl: RTL
=================

Name: adc_spi_ctrl

Overview:
- Sequencer for the scope's analog front end: programs the LTC6912 preamp gain over SPI, then runs periodic LTC1407A conversion frames.
- Generates AD_CONV, the `read` shift window and SPI clock enable consumed directly by the downstream serial ADC reader/FIFO-push stage.
- Sits between the control/UI logic (start, gain) and the ADC reader.

Parameters:
- SAMPLE_DIV, 50, clk cycles per conversion period; legal range 36..65535.
- GAIN_RST, 8'h11, preamp gain word loaded automatically after reset (A and B nibbles, gain -1).
- CNT_W, 16, width of frame_cnt.

Ports:
- clk  in  1  system clock; ADC/amp SPI clock equals clk when spi_sck_en=1.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level; 1 = stream conversions, 0 = stop after current frame.
- gain_wr  in  1  one-cycle strobe, latch gain_in as pending gain.
- gain_in  in  8  new preamp gain word.
- busy  out  1  1 while any amp load or conversion frame is in progress.
- amp_done  out  1  one-cycle pulse when a preamp load completes.
- AMP_CS  out  1  preamp chip select, active low.
- AMP_DIN  out  1  preamp serial data, MSB first.
- AMP_SHDN  out  1  preamp shutdown, held 0 after reset.
- spi_sck_en  out  1  top level gates clk onto SPI_SCK when 1.
- AD_CONV  out  1  one-cycle conversion pulse; also the push strobe for the reader.
- read  out  1  reader shift-enable window.
- frame_cnt  out  CNT_W  completed frame count, wraps to 0.

Behaviour:
- Reset (rst=0): all outputs 0 except AMP_CS=1; state=AMP_LOAD pending with gain=GAIN_RST; frame_cnt=0.
- Reset mid-frame or mid-load aborts immediately. On release, the GAIN_RST load re-runs before any frame.
- States: IDLE, AMP_LOAD, AMP_END, CONV, FRAME, GAP.
- IDLE:
  - Pending gain has priority → AMP_LOAD.
  - Else start=1 → CONV.
  - Else stay.
- AMP_LOAD:
  - AMP_CS=0, spi_sck_en=1 for exactly 8 cycles.
  - AMP_DIN is a shift register updated on negedge clk so each bit is stable across the rising SCK edge; bit 7 first.
  - Then AMP_END.
- AMP_END:
  - 1 cycle with AMP_CS=1 and spi_sck_en=0; amp_done=1; pending flag cleared.
  - Then IDLE.
- CONV:
  - AD_CONV=1 for 1 cycle; period counter reloads to SAMPLE_DIV-1.
  - Then FRAME.
- FRAME:
  - 34 cycles (idx 0..33), spi_sck_en=1.
  - read=1 for idx 2..33 (exactly 32 cycles).
  - Last cycle increments frame_cnt.
  - Then GAP.
- GAP:
  - spi_sck_en=0; wait until period counter reaches 0.
  - Then: pending gain → AMP_LOAD; start=1 → CONV; else IDLE.
- AD_CONV-to-AD_CONV spacing is exactly SAMPLE_DIV cycles while streaming with no gain change. A gain change inserts AMP_LOAD+AMP_END (9 cycles) before the next CONV.
- gain_wr:
  - Accepted in any state; never interrupts a frame or load in progress.
  - A second gain_wr before the load starts overwrites the pending value (last wins).
  - gain_wr in the AMP_END cycle re-arms pending for another load.
- start falling mid-frame: the frame completes, including GAP; then IDLE. The final frame's data is pushed only when the next AD_CONV occurs.
- AD_CONV and read never overlap. AD_CONV is never asserted during AMP_LOAD.
- busy = (state != IDLE).
- frame_cnt wraps from 2^CNT_W-1 to 0.

Test Plan:
- Reset release → AMP_CS low 8 cycles, AMP_DIN serialises 0,0,0,1,0,0,0,1, then amp_done pulse; AD_CONV stays 0 with start=0.
- start=1, SAMPLE_DIV=50 → AD_CONV pulses every 50 cycles; read high 32 cycles starting 3 cycles after AD_CONV; spi_sck_en high 34 cycles per frame.
- gain_wr 8'hA5 mid-frame → current frame unaltered; after GAP, AMP_DIN shifts 1,0,1,0,0,1,0,1; next AD_CONV is 59 cycles after the previous one.
- Two gain_wr (8'h22 then 8'h33) during one frame → only 8'h33 loaded, single amp_done.
- start dropped at frame idx 10 → frame finishes at idx 33, frame_cnt +1, busy falls at the end of GAP, no further AD_CONV.
- rst low at frame idx 20 → all outputs reset within the same cycle; after release, the GAIN_RST load precedes the first AD_CONV. CNT_W=4 with 16 frames → frame_cnt wraps to 0.

Source files
------------

// File: rtl/adc_spi_ctrl.sv
// rtl/adc_spi_ctrl.sv - preamp gain loader and LTC1407A conversion frame sequencer
// Drives AMP_CS/AMP_DIN for the LTC6912, then AD_CONV/read/spi_sck_en frames for the ADC reader.
module adc_spi_ctrl #(
  parameter int unsigned SAMPLE_DIV = 50,
  parameter logic [7:0]  GAIN_RST   = 8'h11,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             gain_wr,
  input  logic [7:0]       gain_in,
  output logic             busy,
  output logic             amp_done,
  output logic             AMP_CS,
  output logic             AMP_DIN,
  output logic             AMP_SHDN,
  output logic             spi_sck_en,
  output logic             AD_CONV,
  output logic             read,
  output logic [CNT_W-1:0] frame_cnt
);
  typedef enum logic [2:0] {S_IDLE, S_AMP_LOAD, S_AMP_END, S_CONV, S_FRAME, S_GAP} state_t;

  localparam logic [15:0] LP_PERIOD     = 16'(SAMPLE_DIV - 1);
  localparam logic [5:0]  LP_AMP_LAST   = 6'd7;
  localparam logic [5:0]  LP_FRAME_LAST = 6'd33;
  localparam logic [5:0]  LP_READ_FIRST = 6'd2;

  state_t           r_state;
  state_t           w_next;
  logic             r_active;
  logic [5:0]       r_idx;
  logic [15:0]      r_period;
  logic [7:0]       r_gain;
  logic             r_pend;
  logic [7:0]       r_amp_sr;
  logic             r_amp_din;
  logic [CNT_W-1:0] r_frame_cnt;
  logic             w_load_en;
  logic             w_load_start;

  // Reset parks the FSM in AMP_LOAD; r_active holds it quiet until the first clock after release.
  assign w_load_en    = r_active && (r_state == S_AMP_LOAD);
  assign w_load_start = (w_next == S_AMP_LOAD) && (r_state != S_AMP_LOAD);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_AMP_END: begin
        if (r_pend)     w_next = S_AMP_LOAD;
        else if (start) w_next = S_CONV;
        else            w_next = S_IDLE;
      end
      S_AMP_LOAD: if (r_active && (r_idx == LP_AMP_LAST)) w_next = S_AMP_END;
      S_CONV:     w_next = S_FRAME;
      S_FRAME:    if (r_idx == LP_FRAME_LAST) w_next = S_GAP;
      S_GAP: begin
        if (r_period == '0) begin
          if (r_pend)     w_next = S_AMP_LOAD;
          else if (start) w_next = S_CONV;
          else            w_next = S_IDLE;
        end
      end
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_AMP_LOAD;
      r_active    <= 1'b0;
      r_idx       <= '0;
      r_period    <= '0;
      r_gain      <= GAIN_RST;
      r_pend      <= 1'b0;
      r_amp_sr    <= GAIN_RST;
      r_frame_cnt <= '0;
    end else begin
      r_active <= 1'b1;
      r_state  <= w_next;

      if (w_next != r_state)
        r_idx <= '0;
      else if (w_load_en || (r_state == S_FRAME))
        r_idx <= r_idx + 6'd1;

      // Loading on entry to CONV makes AD_CONV-to-AD_CONV exactly SAMPLE_DIV cycles.
      if (w_next == S_CONV)
        r_period <= LP_PERIOD;
      else if (r_period != '0)
        r_period <= r_period - 16'd1;

      if (w_load_start) begin
        r_amp_sr <= r_gain;
        r_pend   <= 1'b0;
      end else if (w_load_en) begin
        r_amp_sr <= {r_amp_sr[6:0], 1'b0};
      end

      if (gain_wr) begin
        r_gain <= gain_in;
        r_pend <= 1'b1;
      end

      if ((r_state == S_FRAME) && (r_idx == LP_FRAME_LAST))
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
    end
  end

  // Falling-edge retiming keeps each amp bit stable across the rising SCK edge.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst)
      r_amp_din <= 1'b0;
    else
      r_amp_din <= w_load_en ? r_amp_sr[7] : 1'b0;
  end

  assign busy       = r_active && (r_state != S_IDLE);
  assign amp_done   = (r_state == S_AMP_END);
  assign AMP_CS     = !w_load_en;
  assign AMP_DIN    = r_amp_din;
  assign AMP_SHDN   = 1'b0;
  assign spi_sck_en = w_load_en || (r_state == S_FRAME);
  assign AD_CONV    = (r_state == S_CONV);
  assign read       = (r_state == S_FRAME) && (r_idx >= LP_READ_FIRST);
  assign frame_cnt  = r_frame_cnt;
endmodule
